// File: rtl/io_map_pkg.sv
// Shared CPU IO-bus definitions: widths, default peripheral bases, register
// offsets and the registered load-response record.
package io_map_pkg;
  localparam int IO_DW = 32;
  localparam int IO_AW = 10;

  localparam logic [IO_AW-1:0] IO_LED_BASE = 10'h3E0;
  localparam logic [IO_AW-1:0] IO_SW_BASE  = 10'h3F0;

  typedef enum logic [1:0] {
    REG_LEVEL = 2'd0,
    REG_EDGE  = 2'd1,
    REG_MASK  = 2'd2
  } reg_off_e;

  typedef struct packed {
    logic             vld;
    logic [IO_DW-1:0] data;
  } ld_rsp_t;
endpackage

// File: rtl/io_sw_in_if.sv
// CPU IO load/store bus as seen by a memory-mapped peripheral.
interface io_sw_in_if;
  import io_map_pkg::*;

  logic             ld_re_io;
  logic [IO_AW-1:0] ld_adr_io;
  logic [IO_DW-1:0] ld_data_io;
  logic             ld_vld;
  logic [3:0]       st_we_io;
  logic [IO_AW-1:0] st_adr_io;
  logic [IO_DW-1:0] st_data_io;

  modport master (
    output ld_re_io, ld_adr_io, st_we_io, st_adr_io, st_data_io,
    input  ld_data_io, ld_vld
  );

  modport slave (
    input  ld_re_io, ld_adr_io, st_we_io, st_adr_io, st_data_io,
    output ld_data_io, ld_vld
  );
endinterface

// File: rtl/io_debounce.sv
// Two-flop synchroniser plus prescaled two-sample debounce; a new input value
// is accepted only after it has been seen on consecutive prescaler ticks.
module io_debounce #(
  parameter int NIN       = 4,
  parameter int DB_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NIN-1:0] btn_in,
  output logic [NIN-1:0] level
);
  localparam int            CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [NIN-1:0] sync0_q, sync0_d, sync1_q, sync1_d;
  logic [NIN-1:0] s0_q, s0_d, s1_q, s1_d;
  logic [NIN-1:0] level_q, level_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           tick;

  always_comb begin
    sync0_d = btn_in;
    sync1_d = sync0_q;
    tick    = (cnt_q == CNT_MAX);
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    s0_d    = s0_q;
    s1_d    = s1_q;
    level_d = level_q;
    if (tick) begin
      s0_d    = sync1_q;
      s1_d    = s0_q;
      // bits whose two samples agree take the sampled value, others hold
      level_d = (s1_q & ~(s0_q ^ s1_q)) | (level_q & (s0_q ^ s1_q));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q <= '0;
      sync1_q <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      level_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
endmodule

// File: rtl/io_sw_in.sv
// Memory-mapped switch/button input: debounced LEVEL, sticky rising-edge EDGE
// (read-to-clear), writable MASK and a registered level IRQ.
module io_sw_in
  import io_map_pkg::*;
#(
  parameter int               NIN       = 4,
  parameter logic [IO_AW-1:0] BASE_ADR  = IO_SW_BASE,
  parameter int               DB_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NIN-1:0] btn_in,
  io_sw_in_if.slave      bus,
  output logic           irq
);
  logic [NIN-1:0] level;
  logic [NIN-1:0] level_prev_q, level_prev_d;
  logic [NIN-1:0] edge_q, edge_d;
  logic [NIN-1:0] mask_q, mask_d;
  logic           irq_q, irq_d;
  ld_rsp_t        rsp_q, rsp_d;

  logic [IO_AW:0] ld_adr_x, base_x;
  logic           ld_hit, st_hit;
  reg_off_e       ld_off;
  logic [NIN-1:0] rise, edge_clr;
  logic           unused_st;

  io_debounce #(.NIN(NIN), .DB_CYCLES(DB_CYCLES)) u_db (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_in),
    .level  (level)
  );

  always_comb begin
    // widen by one bit so a base near the top of the IO space cannot wrap
    ld_adr_x = {1'b0, bus.ld_adr_io};
    base_x   = {1'b0, BASE_ADR};
    ld_hit   = bus.ld_re_io && (ld_adr_x >= base_x) &&
               (ld_adr_x <= base_x + (IO_AW+1)'(REG_MASK));
    ld_off   = reg_off_e'(2'(bus.ld_adr_io - BASE_ADR));
    st_hit   = bus.st_we_io[0] && (bus.st_adr_io == BASE_ADR + IO_AW'(REG_MASK));

    rise     = level & ~level_prev_q;
    edge_clr = {NIN{ld_hit && (ld_off == REG_EDGE)}};

    level_prev_d = level;
    edge_d       = (edge_q & ~edge_clr) | rise;
    mask_d       = st_hit ? bus.st_data_io[NIN-1:0] : mask_q;
    irq_d        = |(edge_q & mask_q);

    rsp_d = '0;
    if (ld_hit) begin
      rsp_d.vld = 1'b1;
      case (ld_off)
        REG_LEVEL: rsp_d.data = IO_DW'(level);
        REG_EDGE:  rsp_d.data = IO_DW'(edge_q);
        REG_MASK:  rsp_d.data = IO_DW'(mask_q);
        default:   rsp_d.data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_prev_q <= '0;
      edge_q       <= '0;
      mask_q       <= '0;
      irq_q        <= 1'b0;
      rsp_q        <= '0;
    end else begin
      level_prev_q <= level_prev_d;
      edge_q       <= edge_d;
      mask_q       <= mask_d;
      irq_q        <= irq_d;
      rsp_q        <= rsp_d;
    end
  end

  assign bus.ld_vld     = rsp_q.vld;
  assign bus.ld_data_io = rsp_q.data;
  assign irq            = irq_q;

  assign unused_st = ^{bus.st_we_io[3:1], bus.st_data_io[IO_DW-1:NIN]};
endmodule

// File: tb/tb_io_sw_in.sv
// Scoreboard bench for io_sw_in: expected load responses are queued at issue
// and checked by a monitor one clock later; irq is checked inline.
module tb_io_sw_in;
  localparam logic [9:0] B = 10'h3F0;

  typedef struct {
    bit          vld;
    logic [31:0] data;
    bit          cmp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btn;
  logic        irq;
  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          issued;
  logic [31:0] last_rd;
  bit          found;

  io_sw_in_if bus ();

  io_sw_in #(.NIN(4), .BASE_ADR(B), .DB_CYCLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn),
    .bus    (bus.slave),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic ld(input logic [9:0] a, input bit ev, input logic [31:0] ed, input bit cmp = 1'b1);
    exp_t e;
    e.vld = ev; e.data = ed; e.cmp = cmp;
    sb.push_back(e);
    bus.ld_re_io  = 1'b1;
    bus.ld_adr_io = a;
    @(negedge clk);
    bus.ld_re_io  = 1'b0;
    bus.ld_adr_io = '0;
  endtask

  task automatic st(input logic [9:0] a, input logic [3:0] we, input logic [31:0] d);
    bus.st_we_io   = we;
    bus.st_adr_io  = a;
    bus.st_data_io = d;
    @(negedge clk);
    bus.st_we_io   = '0;
  endtask

  // monitor: one response per issued load, idle outputs otherwise
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      issued = bus.ld_re_io;
      #1;
      if (issued) begin
        chk("sb_pending", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("ld_vld", 64'(bus.ld_vld), 64'(e.vld));
          if (e.cmp) chk("ld_data", 64'(bus.ld_data_io), 64'(e.data));
          last_rd = bus.ld_data_io;
        end
      end else begin
        chk("idle_out", 64'({bus.ld_vld, bus.ld_data_io}), 64'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; btn = '0;
    bus.ld_re_io = 1'b0; bus.ld_adr_io = '0;
    bus.st_we_io = '0; bus.st_adr_io = '0; bus.st_data_io = '0;
    repeat (3) @(negedge clk);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_vld", 64'(bus.ld_vld), 64'd0);
    rst = 1'b0;

    ld(B, 1'b1, 32'h0);
    chk("irq_idle", 64'(irq), 64'd0);

    // debounced level and rising-edge capture
    btn = 4'b0101;
    repeat (20) @(negedge clk);
    ld(B,         1'b1, 32'h5);
    ld(B + 10'd1, 1'b1, 32'h5);
    ld(B + 10'd1, 1'b1, 32'h0);

    // glitch shorter than a tick period
    btn = 4'b1101;
    repeat (3) @(negedge clk);
    btn = 4'b0101;
    repeat (20) @(negedge clk);
    ld(B,         1'b1, 32'h5);
    ld(B + 10'd1, 1'b1, 32'h0);

    // ignored stores, then mask write
    st(B + 10'd2, 4'b1110, 32'hF);
    st(B,         4'b1111, 32'hF);
    st(B + 10'd1, 4'b1111, 32'hF);
    ld(B + 10'd2, 1'b1, 32'h0);
    ld(B,         1'b1, 32'h5);
    st(B + 10'd2, 4'b0001, 32'h2);
    chk("irq_masked_idle", 64'(irq), 64'd0);

    btn = 4'b0111;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (irq) found = 1'b1;
    end
    chk("irq_set", 64'(irq), 64'd1);
    ld(B + 10'd1, 1'b1, 32'h2);
    chk("irq_hold", 64'(irq), 64'd1);
    @(negedge clk);
    chk("irq_clr", 64'(irq), 64'd0);
    ld(B + 10'd2, 1'b1, 32'h2);

    // load of MASK in the cycle it is written returns the old value
    sb.push_back('{vld: 1'b1, data: 32'h2, cmp: 1'b1});
    bus.ld_re_io = 1'b1; bus.ld_adr_io = B + 10'd2;
    bus.st_we_io = 4'b0001; bus.st_adr_io = B + 10'd2; bus.st_data_io = 32'h3;
    @(negedge clk);
    bus.ld_re_io = 1'b0; bus.st_we_io = '0;
    ld(B + 10'd2, 1'b1, 32'h3);

    // falling edge ignored
    btn = 4'b0110;
    repeat (20) @(negedge clk);
    ld(B,         1'b1, 32'h6);
    ld(B + 10'd1, 1'b1, 32'h0);

    // back-to-back EDGE reads: the set cycle always coincides with a clear
    btn = 4'b0111;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      ld(B + 10'd1, 1'b1, 32'h0, 1'b0);
      if (last_rd != 32'h0) found = 1'b1;
    end
    chk("edge_collide", 64'(last_rd), 64'h1);
    ld(B + 10'd1, 1'b1, 32'h0);

    // out-of-range addresses
    ld(10'h3F3, 1'b0, 32'h0);
    ld(10'h3EF, 1'b0, 32'h0);

    // reset during a load drops it and clears all registers
    sb.push_back('{vld: 1'b0, data: 32'h0, cmp: 1'b1});
    bus.ld_re_io = 1'b1; bus.ld_adr_io = B;
    rst = 1'b1;
    @(negedge clk);
    bus.ld_re_io = 1'b0;
    rst = 1'b0;
    chk("rst_mid_irq", 64'(irq), 64'd0);
    ld(B,         1'b1, 32'h0);
    ld(B + 10'd1, 1'b1, 32'h0);
    ld(B + 10'd2, 1'b1, 32'h0);

    repeat (3) @(negedge clk);
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
